// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and widths for the 5-stage 24-bit pipeline control path.
//   hz_state_t : hazard controller FSM states (RUN, MEM_WAIT)
//   fwd_sel_t  : ALU operand source select (register file, EX/MEM, MEM/WB)
//   REG_W      : register-index width used by all pipeline registers
//   DATA_W     : datapath width of the pipeline
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 24;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit
// Purely combinational forwarding-select logic for one ALU operand.
// Ports:
//   src_i       source register read by the instruction in ID
//   uses_i      the instruction actually reads src_i
//   mem_dest_i  destination held in EX/MEM
//   mem_wb_en_i / mem_rd_en_i  EX/MEM writeback and load bits
//   wb_dest_i   destination held in MEM/WB
//   wb_wb_en_i  MEM/WB writeback bit
//   sel_o       0 = register file, 1 = EX/MEM alu_result, 2 = MEM/WB result
// -----------------------------------------------------------------------------
module fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] src_i,
  input  logic             uses_i,
  input  logic [REG_W-1:0] mem_dest_i,
  input  logic             mem_wb_en_i,
  input  logic             mem_rd_en_i,
  input  logic [REG_W-1:0] wb_dest_i,
  input  logic             wb_wb_en_i,
  output logic [1:0]       sel_o
);

  // A load in MEM has no result yet on the alu_result path, so it is skipped
  // here; the load-use stall guarantees it is picked up from MEM/WB instead.
  // The younger producer in MEM takes priority over WB. Register 0 forwards
  // like any other register.
  always_comb begin
    sel_o = FWD_RF;
    if (uses_i) begin
      if (mem_wb_en_i && !mem_rd_en_i && (mem_dest_i == src_i)) begin
        sel_o = FWD_MEM;
      end else if (wb_wb_en_i && (wb_dest_i == src_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central hazard and sequencing controller for the 5-stage pipeline. Every
// cycle it decides whether each pipeline register advances, holds or takes a
// bubble, produces the ALU forwarding selects, tracks the multi-cycle data
// memory handshake and counts stall cycles.
// Parameters:
//   MAX_WAIT  memory wait cycles before mem_timeout is raised
//   CNT_W     width of the saturating stall-cycle counter
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   id_*                     sources / use bits of the instruction in ID
//   ex_*, mem_*, wb_*        destination and control bits of ID/EX, EX/MEM,
//                            MEM/WB
//   branch_taken             EX resolved a taken branch or jump
//   mem_ready                data memory completes its access this cycle
//   *_stall                  hold the corresponding register (combinational)
//   *_flush                  load a bubble (combinational)
//   fwd_a_sel, fwd_b_sel     operand forwarding selects (combinational)
//   mem_timeout              sticky: a memory access waited MAX_WAIT cycles
//   stall_cycles             saturating count of cycles with pc_stall high
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 32,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_src_a,
  input  logic [REG_W-1:0] id_src_b,
  input  logic             id_uses_a,
  input  logic             id_uses_b,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_writeback_enable,
  input  logic             ex_mem_read_enable,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_writeback_enable,
  input  logic             mem_read_enable,
  input  logic             mem_write_enable,
  input  logic [REG_W-1:0] wb_dest,
  input  logic             wb_writeback_enable,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  hz_state_t         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic              mem_busy;
  logic              load_use;
  logic [1:0]        fwd_a_raw, fwd_b_raw;

  // ---------------------------------------------------------------------------
  // Hazard detection (combinational)
  // ---------------------------------------------------------------------------
  // mem_ready without an access in flight does not create or end a wait.
  assign mem_busy = (mem_read_enable | mem_write_enable) & ~mem_ready;

  assign load_use = ex_mem_read_enable & ex_writeback_enable &
                    ((id_uses_a & (ex_dest == id_src_a)) |
                     (id_uses_b & (ex_dest == id_src_b)));

  fwd_unit u_fwd_a (
    .src_i       (id_src_a),
    .uses_i      (id_uses_a),
    .mem_dest_i  (mem_dest),
    .mem_wb_en_i (mem_writeback_enable),
    .mem_rd_en_i (mem_read_enable),
    .wb_dest_i   (wb_dest),
    .wb_wb_en_i  (wb_writeback_enable),
    .sel_o       (fwd_a_raw)
  );

  fwd_unit u_fwd_b (
    .src_i       (id_src_b),
    .uses_i      (id_uses_b),
    .mem_dest_i  (mem_dest),
    .mem_wb_en_i (mem_writeback_enable),
    .mem_rd_en_i (mem_read_enable),
    .wb_dest_i   (wb_dest),
    .wb_wb_en_i  (wb_writeback_enable),
    .sel_o       (fwd_b_raw)
  );

  // Priority: memory wait > taken branch > load-use. A branch held in EX
  // during a wait is not flushed until the wait releases, because the
  // instructions behind it are frozen rather than advancing.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    fwd_a_sel    = 2'd0;
    fwd_b_sel    = 2'd0;
    if (!rst) begin
      if (mem_busy) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (branch_taken) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_flush  = 1'b1;
      end
      fwd_a_sel = fwd_a_raw;
      fwd_b_sel = fwd_b_raw;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state: FSM, wait counter, timeout, stall profiling
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = mem_busy ? MEM_WAIT : RUN;
    wait_cnt_d  = wait_cnt_q;
    if (mem_busy) begin
      // Saturate so a hung memory cannot wrap the counter back below MAX_WAIT.
      if (wait_cnt_q != WAIT_MAX) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end else if (state_q == MEM_WAIT) begin
      wait_cnt_d = '0;
    end
    timeout_d   = timeout_q | (wait_cnt_d == WAIT_MAX);
    stall_cnt_d = stall_cnt_q;
    if (pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int TB_MAX_WAIT = 32;
  localparam int TB_CNT_W    = 5;
  localparam int CNT_SAT     = (1 << TB_CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] id_src_a, id_src_b, ex_dest, mem_dest, wb_dest;
  logic       id_uses_a, id_uses_b;
  logic       ex_writeback_enable, ex_mem_read_enable;
  logic       mem_writeback_enable, mem_read_enable, mem_write_enable;
  logic       wb_writeback_enable, branch_taken, mem_ready;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic       if_id_flush, id_ex_flush, mem_wb_flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       mem_timeout;
  logic [TB_CNT_W-1:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_stall_cnt = 0;
  int m_busy_run  = 0;
  bit m_timeout   = 0;

  pipe_hazard_ctrl #(.MAX_WAIT(TB_MAX_WAIT), .CNT_W(TB_CNT_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .id_src_a             (id_src_a),
    .id_src_b             (id_src_b),
    .id_uses_a            (id_uses_a),
    .id_uses_b            (id_uses_b),
    .ex_dest              (ex_dest),
    .ex_writeback_enable  (ex_writeback_enable),
    .ex_mem_read_enable   (ex_mem_read_enable),
    .mem_dest             (mem_dest),
    .mem_writeback_enable (mem_writeback_enable),
    .mem_read_enable      (mem_read_enable),
    .mem_write_enable     (mem_write_enable),
    .wb_dest              (wb_dest),
    .wb_writeback_enable  (wb_writeback_enable),
    .branch_taken         (branch_taken),
    .mem_ready            (mem_ready),
    .pc_stall             (pc_stall),
    .if_id_stall          (if_id_stall),
    .id_ex_stall          (id_ex_stall),
    .ex_mem_stall         (ex_mem_stall),
    .if_id_flush          (if_id_flush),
    .id_ex_flush          (id_ex_flush),
    .mem_wb_flush         (mem_wb_flush),
    .fwd_a_sel            (fwd_a_sel),
    .fwd_b_sel            (fwd_b_sel),
    .mem_timeout          (mem_timeout),
    .stall_cycles         (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int ref_fwd(input logic [3:0] src, input logic uses);
    if (!uses) return 0;
    if (mem_writeback_enable && !mem_read_enable && mem_dest == src) return 1;
    if (wb_writeback_enable && wb_dest == src) return 2;
    return 0;
  endfunction

  // Evaluate the reference at mid-cycle, compare, then advance the model
  // across the coming rising edge.
  task automatic step();
    bit busy, lu, e_stall_fe, e_stall_be, e_ifid_fl, e_idex_fl, e_memwb_fl;
    int e_fa, e_fb;
    @(negedge clk);
    busy = (mem_read_enable || mem_write_enable) && !mem_ready;
    lu   = ex_mem_read_enable && ex_writeback_enable &&
           ((id_uses_a && ex_dest == id_src_a) || (id_uses_b && ex_dest == id_src_b));
    e_stall_fe = 0; e_stall_be = 0; e_ifid_fl = 0; e_idex_fl = 0; e_memwb_fl = 0;
    e_fa = 0; e_fb = 0;
    if (!rst) begin
      if (busy) begin
        e_stall_fe = 1; e_stall_be = 1; e_memwb_fl = 1;
      end else if (branch_taken) begin
        e_ifid_fl = 1; e_idex_fl = 1;
      end else if (lu) begin
        e_stall_fe = 1; e_idex_fl = 1;
      end
      e_fa = ref_fwd(id_src_a, id_uses_a);
      e_fb = ref_fwd(id_src_b, id_uses_b);
    end
    check_val("pc_stall",     32'(pc_stall),     32'(e_stall_fe));
    check_val("if_id_stall",  32'(if_id_stall),  32'(e_stall_fe));
    check_val("id_ex_stall",  32'(id_ex_stall),  32'(e_stall_be));
    check_val("ex_mem_stall", 32'(ex_mem_stall), 32'(e_stall_be));
    check_val("if_id_flush",  32'(if_id_flush),  32'(e_ifid_fl));
    check_val("id_ex_flush",  32'(id_ex_flush),  32'(e_idex_fl));
    check_val("mem_wb_flush", 32'(mem_wb_flush), 32'(e_memwb_fl));
    check_val("fwd_a_sel",    32'(fwd_a_sel),    32'(e_fa));
    check_val("fwd_b_sel",    32'(fwd_b_sel),    32'(e_fb));
    check_val("mem_timeout",  32'(mem_timeout),  32'(m_timeout));
    check_val("stall_cycles", 32'(stall_cycles), 32'(m_stall_cnt));
    if (rst) begin
      m_stall_cnt = 0; m_busy_run = 0; m_timeout = 0;
    end else begin
      if (e_stall_fe && m_stall_cnt < CNT_SAT) m_stall_cnt++;
      m_busy_run = busy ? m_busy_run + 1 : 0;
      if (m_busy_run >= TB_MAX_WAIT) m_timeout = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_src_a = 0; id_src_b = 0; id_uses_a = 0; id_uses_b = 0;
    ex_dest = 0; ex_writeback_enable = 0; ex_mem_read_enable = 0;
    mem_dest = 0; mem_writeback_enable = 0; mem_read_enable = 0; mem_write_enable = 0;
    wb_dest = 0; wb_writeback_enable = 0; branch_taken = 0; mem_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1; step(); rst = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); #1;
    step();
    check_val("rst_stall_cycles", 32'(stall_cycles), 0);
    check_val("rst_timeout", 32'(mem_timeout), 0);
    rst = 0;

    // Load-use: one stall, then the load reaches WB and forwards from there
    idle();
    ex_dest = 2; ex_mem_read_enable = 1; ex_writeback_enable = 1;
    id_src_a = 2; id_uses_a = 1;
    step();
    check_val("lu_stall_cycles", 32'(stall_cycles), 1);
    idle();
    mem_dest = 2; mem_writeback_enable = 1; mem_read_enable = 1; mem_ready = 1;
    id_src_a = 2; id_uses_a = 1;
    step();
    idle();
    wb_dest = 2; wb_writeback_enable = 1; id_src_a = 2; id_uses_a = 1;
    step();

    // Forwarding priority: MEM over WB, loads in MEM do not forward
    idle();
    mem_dest = 1; mem_writeback_enable = 1; wb_dest = 1; wb_writeback_enable = 1;
    id_src_b = 1; id_uses_b = 1;
    step();
    mem_read_enable = 1; mem_ready = 1;
    step();
    // Register 0 forwards too
    idle();
    mem_dest = 0; mem_writeback_enable = 1; id_uses_a = 1; id_uses_b = 1;
    step();

    // Memory wait: 3 busy cycles, release on the 4th
    do_reset();
    idle();
    mem_read_enable = 1; mem_ready = 0;
    repeat (3) step();
    mem_ready = 1;
    step();
    check_val("wait_stall_cycles", 32'(stall_cycles), 3);
    idle();
    step();

    // Branch held in EX during a wait flushes on release
    idle();
    branch_taken = 1; mem_read_enable = 1; mem_ready = 0;
    repeat (2) step();
    mem_ready = 1;
    step();
    idle();
    step();

    // Timeout after MAX_WAIT cycles, sticky until reset
    do_reset();
    idle();
    mem_write_enable = 1; mem_ready = 0;
    repeat (TB_MAX_WAIT) step();
    mem_ready = 1;
    step();
    check_val("timeout_set", 32'(mem_timeout), 1);
    idle();
    step();
    check_val("timeout_sticky", 32'(mem_timeout), 1);
    rst = 1;
    step();
    rst = 0;
    check_val("timeout_cleared", 32'(mem_timeout), 0);
    check_val("timeout_stall_clr", 32'(stall_cycles), 0);
    step();

    // Reset in the 2nd cycle of MEM_WAIT aborts the wait
    idle();
    mem_read_enable = 1; mem_ready = 0;
    repeat (2) step();
    rst = 1;
    step();
    rst = 0;
    check_val("midwait_stall_cycles", 32'(stall_cycles), 0);
    idle();
    step();

    // Stall counter saturation
    do_reset();
    idle();
    mem_read_enable = 1; mem_ready = 0;
    repeat (CNT_SAT + 6) step();
    check_val("stall_saturated", 32'(stall_cycles), CNT_SAT);
    mem_ready = 1;
    step();
    idle();

    // Randomized traffic; small register range to provoke collisions
    repeat (3000) begin
      rst                  = ($urandom_range(0, 199) == 0);
      id_src_a             = 4'($urandom_range(0, 3));
      id_src_b             = 4'($urandom_range(0, 3));
      id_uses_a            = 1'($urandom);
      id_uses_b            = 1'($urandom);
      ex_dest              = 4'($urandom_range(0, 3));
      ex_writeback_enable  = 1'($urandom);
      ex_mem_read_enable   = 1'($urandom);
      mem_dest             = 4'($urandom_range(0, 3));
      mem_writeback_enable = 1'($urandom);
      mem_read_enable      = ($urandom_range(0, 9) < 3);
      mem_write_enable     = ($urandom_range(0, 9) < 2);
      wb_dest              = 4'($urandom_range(0, 3));
      wb_writeback_enable  = 1'($urandom);
      branch_taken         = ($urandom_range(0, 9) < 2);
      mem_ready            = ($urandom_range(0, 9) < 6);
      step();
    end
    rst = 0;
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
